// File: rtl/mips_sc_pkg.sv
// Shared encodings for the 16-bit MIPS single-cycle controller:
// opcodes, ALU ops, PC-source selects, window modes and the RUN/HALT state.
package mips_sc_pkg;

    // Opcodes (inst[15:12])
    localparam logic [3:0] OPC_LW   = 4'b0000;
    localparam logic [3:0] OPC_SW   = 4'b0001;
    localparam logic [3:0] OPC_J    = 4'b0010;
    localparam logic [3:0] OPC_BZ   = 4'b0100;
    localparam logic [3:0] OPC_ALUR = 4'b1000;
    localparam logic [3:0] OPC_LI   = 4'b1100;
    localparam logic [3:0] OPC_WND  = 4'b1110;
    localparam logic [3:0] OPC_HALT = 4'b1111;

    // ALU operations
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_NOTA = 3'b100;

    // PC source selects
    localparam logic [1:0] PC_JMP = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_INC = 2'd2;

    // Register-window modes (inst[11:10] of a WND instruction)
    localparam logic [1:0] WND_SET = 2'b00;
    localparam logic [1:0] WND_INC = 2'b01;
    localparam logic [1:0] WND_DEC = 2'b10;
    localparam logic [1:0] WND_BAD = 2'b11;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } ctrl_state_e;

    // Next window value for a legal WND mode; 3-bit arithmetic gives the wrap.
    function automatic logic [2:0] wnd_next(input logic [2:0] cur,
                                            input logic [1:0] mode,
                                            input logic [2:0] imm);
        logic [2:0] nxt;
        nxt = cur;
        case (mode)
            WND_SET: nxt = imm;
            WND_INC: nxt = cur + 3'd1;
            WND_DEC: nxt = cur - 3'd1;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mips_sc_decoder.sv
// Purely combinational instruction decoder: maps the instruction word and
// the ALU zero flag to raw datapath controls plus halt/window/illegal flags.
// Illegal encodings leave every control at its NOP default.
module mips_sc_decoder
    import mips_sc_pkg::*;
(
    input  logic [15:0] inst_i,
    input  logic        zero_i,
    output logic [1:0]  pc_src_o,
    output logic        rf_write_o,
    output logic        alu_src_o,
    output logic        alu_sel_o,
    output logic        mem_write_o,
    output logic        mem_read_o,
    output logic        memtoreg_o,
    output logic [2:0]  op_o,
    output logic        is_halt_o,
    output logic        is_wnd_o,
    output logic        is_ill_o
);

    logic [3:0] opc;
    logic [1:0] mode;
    logic [2:0] func;
    logic       unused_bits;

    assign opc  = inst_i[15:12];
    assign mode = inst_i[11:10];
    assign func = inst_i[2:0];
    // Address/immediate bits feed the datapath directly, not the decoder.
    assign unused_bits = ^inst_i[9:3];

    // Opcode decode with NOP defaults assigned first.
    always_comb begin
        pc_src_o    = PC_INC;
        rf_write_o  = 1'b0;
        alu_src_o   = 1'b0;
        alu_sel_o   = 1'b0;
        mem_write_o = 1'b0;
        mem_read_o  = 1'b0;
        memtoreg_o  = 1'b1;
        op_o        = ALU_ADD;
        is_halt_o   = 1'b0;
        is_wnd_o    = 1'b0;
        is_ill_o    = 1'b0;
        case (opc)
            OPC_LW: begin
                rf_write_o = 1'b1;
                mem_read_o = 1'b1;
                memtoreg_o = 1'b0;
            end
            OPC_SW: begin
                alu_sel_o   = 1'b1;
                mem_write_o = 1'b1;
            end
            OPC_J: pc_src_o = PC_JMP;
            OPC_BZ: begin
                alu_sel_o = 1'b1;
                alu_src_o = 1'b1;
                op_o      = ALU_SUB;
                pc_src_o  = zero_i ? PC_BR : PC_INC;
            end
            OPC_ALUR: begin
                if (func > ALU_NOTA) begin
                    is_ill_o = 1'b1;
                end else begin
                    alu_sel_o  = 1'b1;
                    rf_write_o = 1'b1;
                    op_o       = func;
                end
            end
            OPC_LI: begin
                alu_src_o  = 1'b1;
                rf_write_o = 1'b1;
            end
            OPC_WND: begin
                if (mode == WND_BAD) is_ill_o = 1'b1;
                else                 is_wnd_o = 1'b1;
            end
            OPC_HALT: begin
                pc_src_o  = PC_JMP;
                is_halt_o = 1'b1;
            end
            default: is_ill_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_sc_ctrl.sv
// Single-cycle controller top: RUN/HALT FSM, register-window pointer,
// sticky illegal-instruction flag, optional retired-instruction counter,
// and the reset/HALT gating of the decoder's raw controls.
// Optional feature macro: MIPS_CTRL_RETIRE_CNT_EN (retire counter).
module mips_sc_ctrl
    import mips_sc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] inst,
    input  logic        zero,
    output logic [1:0]  sig_pc_src,
    output logic        sig_rf_write,
    output logic        sig_alu_src,
    output logic        sig_alu_sel,
    output logic        sig_mem_write,
    output logic        sig_mem_read,
    output logic        sig_memtoreg,
    output logic [2:0]  sig_rf_wnd,
    output logic [2:0]  sig_op,
    output logic        halted,
    output logic        ill_err,
    output logic [15:0] retire_cnt
);

    logic [1:0]  dec_pc_src;
    logic        dec_rf_write;
    logic        dec_mem_write;
    logic        dec_mem_read;
    logic        is_halt;
    logic        is_wnd;
    logic        is_ill;

    ctrl_state_e state_q, state_d;
    logic [2:0]  wnd_q, wnd_d;
    logic        ill_q, ill_d;
    logic        running;

    mips_sc_decoder u_dec (
        .inst_i      (inst),
        .zero_i      (zero),
        .pc_src_o    (dec_pc_src),
        .rf_write_o  (dec_rf_write),
        .alu_src_o   (sig_alu_src),
        .alu_sel_o   (sig_alu_sel),
        .mem_write_o (dec_mem_write),
        .mem_read_o  (dec_mem_read),
        .memtoreg_o  (sig_memtoreg),
        .op_o        (sig_op),
        .is_halt_o   (is_halt),
        .is_wnd_o    (is_wnd),
        .is_ill_o    (is_ill)
    );

    assign running = (state_q == ST_RUN);

    // Next state, window and error flag; all side effects only while running.
    always_comb begin
        state_d = state_q;
        wnd_d   = wnd_q;
        ill_d   = ill_q;
        if (running) begin
            if (is_halt) state_d = ST_HALT;
            if (is_wnd)  wnd_d   = wnd_next(wnd_q, inst[11:10], inst[2:0]);
            if (is_ill)  ill_d   = 1'b1;
        end
    end

    // Architectural state registers; reset discards any pending effects.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            wnd_q   <= 3'd0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wnd_q   <= wnd_d;
            ill_q   <= ill_d;
        end
    end

    // Output gating: reset forces a safe PC+1 NOP, HALT parks the PC.
    always_comb begin
        sig_pc_src    = dec_pc_src;
        sig_rf_write  = dec_rf_write;
        sig_mem_write = dec_mem_write;
        sig_mem_read  = dec_mem_read;
        if (rst) begin
            sig_pc_src    = PC_INC;
            sig_rf_write  = 1'b0;
            sig_mem_write = 1'b0;
            sig_mem_read  = 1'b0;
        end else if (!running) begin
            sig_pc_src    = PC_JMP;
            sig_rf_write  = 1'b0;
            sig_mem_write = 1'b0;
            sig_mem_read  = 1'b0;
        end
    end

    assign sig_rf_wnd = wnd_q;
    assign halted     = (state_q == ST_HALT);
    assign ill_err    = ill_q;

`ifdef MIPS_CTRL_RETIRE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count of cycles spent in RUN.
    always_comb begin
        cnt_d = cnt_q;
        if (running && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    // Retire counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 16'd0;
        else     cnt_q <= cnt_d;
    end

    assign retire_cnt = cnt_q;
`else
    assign retire_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mips_sc_ctrl.sv
// Self-checking bench for mips_sc_ctrl: directed scenarios followed by
// randomized instruction streams, compared every cycle to a behavioural model.
module tb_mips_sc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] inst;
    logic        zero;
    logic [1:0]  sig_pc_src;
    logic        sig_rf_write;
    logic        sig_alu_src;
    logic        sig_alu_sel;
    logic        sig_mem_write;
    logic        sig_mem_read;
    logic        sig_memtoreg;
    logic [2:0]  sig_rf_wnd;
    logic [2:0]  sig_op;
    logic        halted;
    logic        ill_err;
    logic [15:0] retire_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    int m_halted;
    int m_ill;
    int m_wnd;
    int m_cnt;

    mips_sc_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .inst          (inst),
        .zero          (zero),
        .sig_pc_src    (sig_pc_src),
        .sig_rf_write  (sig_rf_write),
        .sig_alu_src   (sig_alu_src),
        .sig_alu_sel   (sig_alu_sel),
        .sig_mem_write (sig_mem_write),
        .sig_mem_read  (sig_mem_read),
        .sig_memtoreg  (sig_memtoreg),
        .sig_rf_wnd    (sig_rf_wnd),
        .sig_op        (sig_op),
        .halted        (halted),
        .ill_err       (ill_err),
        .retire_cnt    (retire_cnt)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t inst=%h rst=%b zero=%b got=%h exp=%h",
                     tag, $time, inst, rst, zero, got, exp);
        end
    endtask

    function automatic bit is_illegal(input logic [15:0] i);
        int opc;
        opc = int'(i[15:12]);
        if (opc == 8)  return int'(i[2:0]) >= 5;
        if (opc == 14) return int'(i[11:10]) == 3;
        return !(opc == 0 || opc == 1 || opc == 2 || opc == 4 || opc == 12 || opc == 15);
    endfunction

    // Expected controls packed as {pc_src, rf_write, alu_src, alu_sel, mem_write, mem_read, memtoreg, op}.
    function automatic logic [31:0] model_ctrl(input logic r, input logic [15:0] i, input logic z);
        int pc, rfw, as, asel, mw, mr, m2r, op, opc;
        pc = 2; rfw = 0; as = 0; asel = 0; mw = 0; mr = 0; m2r = 1; op = 0;
        opc = int'(i[15:12]);
        if (!is_illegal(i)) begin
            case (opc)
                0:  begin rfw = 1; mr = 1; m2r = 0; end
                1:  begin asel = 1; mw = 1; end
                2:  pc = 0;
                4:  begin asel = 1; as = 1; op = 1; pc = z ? 1 : 2; end
                8:  begin asel = 1; rfw = 1; op = int'(i[2:0]); end
                12: begin as = 1; rfw = 1; end
                15: pc = 0;
                default: ;
            endcase
        end
        if (r) begin
            pc = 2; rfw = 0; mw = 0; mr = 0;
        end else if (m_halted != 0) begin
            pc = 0; rfw = 0; mw = 0; mr = 0;
        end
        return 32'(pc * 512 + rfw * 256 + as * 128 + asel * 64 + mw * 32 + mr * 16 + m2r * 8 + op);
    endfunction

    task automatic model_edge(input logic r, input logic [15:0] i);
        int opc, mode;
        if (r) begin
            m_halted = 0; m_ill = 0; m_wnd = 0; m_cnt = 0;
        end else if (m_halted == 0) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            opc  = int'(i[15:12]);
            mode = int'(i[11:10]);
            if (is_illegal(i)) m_ill = 1;
            else if (opc == 15) m_halted = 1;
            else if (opc == 14) begin
                if (mode == 0) m_wnd = int'(i[2:0]);
                else if (mode == 1) m_wnd = (m_wnd + 1) % 8;
                else m_wnd = (m_wnd + 7) % 8;
            end
        end
    endtask

    task automatic check_state();
        int exp_cnt;
`ifdef MIPS_CTRL_RETIRE_CNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 0;
`endif
        check("halted", 32'(halted), 32'(m_halted));
        check("ill_err", 32'(ill_err), 32'(m_ill));
        check("wnd", 32'(sig_rf_wnd), 32'(m_wnd));
        check("retire_cnt", 32'(retire_cnt), 32'(exp_cnt));
    endtask

    // driver: apply one cycle, check comb outputs and current state, advance model
    task automatic step(input logic r, input logic [15:0] i, input logic z);
        @(negedge clk);
        rst = r; inst = i; zero = z;
        #1;
        check("ctrl", {21'd0, sig_pc_src, sig_rf_write, sig_alu_src, sig_alu_sel,
                       sig_mem_write, sig_mem_read, sig_memtoreg, sig_op},
              model_ctrl(r, i, z));
        check_state();
        @(posedge clk);
        model_edge(r, i);
    endtask

    function automatic logic [15:0] rand_inst();
        logic [3:0] opc;
        int pick;
        pick = $urandom_range(0, 19);
        case (pick)
            0, 1:   opc = 4'h0;
            2, 3:   opc = 4'h1;
            4:      opc = 4'h2;
            5, 6:   opc = 4'h4;
            7, 8, 9: opc = 4'h8;
            10, 11: opc = 4'hC;
            12, 13, 14, 15: opc = 4'hE;
            16:     opc = 4'hF;
            default: opc = 4'($urandom_range(0, 15));
        endcase
        return {opc, 12'($urandom)};
    endfunction

    initial begin
        // raw reset cycle to bring the DUT to a known state
        rst = 1'b1; inst = 16'h0000; zero = 1'b0;
        @(posedge clk);
        model_edge(1'b1, 16'h0000);

        // reset held
        step(1'b1, 16'h0000, 1'b0);
        step(1'b1, 16'h0000, 1'b0);

        // BZ taken / not taken
        step(1'b0, 16'h4412, 1'b1);
        step(1'b0, 16'h4412, 1'b0);

        // window sequence and wrap in both directions
        step(1'b0, 16'hE005, 1'b0);
        step(1'b0, 16'hE400, 1'b0);
        step(1'b0, 16'hE400, 1'b0);
        step(1'b0, 16'hE800, 1'b0);
        step(1'b0, 16'hE007, 1'b0);
        step(1'b0, 16'hE400, 1'b0);
        step(1'b0, 16'hE800, 1'b0);

        // ALU-R, LI, LW, SW
        step(1'b0, 16'h8403, 1'b0);
        step(1'b0, 16'hC4AB, 1'b0);
        step(1'b0, 16'h0123, 1'b0);
        step(1'b0, 16'h1123, 1'b0);
        step(1'b0, 16'h2155, 1'b0);

        // HALT, blocked instruction while halted, reset exits
        step(1'b0, 16'hF010, 1'b0);
        step(1'b0, 16'h8400, 1'b0);
        step(1'b0, 16'h0123, 1'b0);
        step(1'b1, 16'h8400, 1'b0);
        step(1'b0, 16'h8400, 1'b0);

        // illegal opcodes set a sticky flag
        step(1'b0, 16'h3000, 1'b0);
        step(1'b0, 16'h8407, 1'b0);
        step(1'b0, 16'hEC00, 1'b0);
        step(1'b0, 16'hC401, 1'b0);
        step(1'b0, 16'h8401, 1'b0);

        // reset discards a pending illegal and WND in the same cycle
        step(1'b1, 16'hE003, 1'b0);
        step(1'b1, 16'h3000, 1'b0);

        // five RUN instructions (HALT last) then three halted cycles
        step(1'b0, 16'hC401, 1'b0);
        step(1'b0, 16'h8400, 1'b0);
        step(1'b0, 16'h0010, 1'b0);
        step(1'b0, 16'h1010, 1'b0);
        step(1'b0, 16'hF024, 1'b0);
        step(1'b0, 16'hE400, 1'b1);
        step(1'b0, 16'h3000, 1'b0);
        step(1'b0, 16'hF024, 1'b0);
        step(1'b1, 16'h0000, 1'b0);

        // randomized stream with occasional resets
        for (int n = 0; n < 800; n++) begin
            logic r;
            if (m_halted != 0) r = ($urandom_range(0, 3) == 0);
            else               r = ($urandom_range(0, 39) == 0);
            step(r, rand_inst(), 1'($urandom));
        end

        // final state after the last edge
        @(negedge clk);
        #1;
        check_state();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_sc_ctrl.md
# mips_sc_ctrl

Single-cycle controller for the 16-bit MIPS datapath. It decodes the instruction word fetched from IM and, with the ALU `zero` flag, drives every datapath control strobe in the same cycle. It also holds the architectural state the datapath lacks: the register-window pointer, the RUN/HALT state, a sticky illegal-opcode flag, and an optional retired-instruction counter.

## Interface
Parameters:
- none; all encodings come from `mips_sc_pkg`.

Ports:
- `clk`  in  1  system clock; every flop updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `inst`  in  16  current instruction word from IM.
- `zero`  in  1  ALU zero flag, same cycle.
- `sig_pc_src`  out  2  PC source: 0 = `inst[9:0]`, 1 = `{pc[9:8],inst[7:0]}`, 2 = PC+1.
- `sig_rf_write`  out  1  register-file write enable.
- `sig_alu_src`  out  1  ALU B select: 0 = RF out2, 1 = 16'h0000.
- `sig_alu_sel`  out  1  ALU A select: 0 = `{8'h00,inst[7:0]}`, 1 = RF out1.
- `sig_mem_write`  out  1  data-memory write enable.
- `sig_mem_read`  out  1  data-memory read enable.
- `sig_memtoreg`  out  1  RF write-data select: 0 = MEM out, 1 = ALU out.
- `sig_rf_wnd`  out  3  current register window, driven from a register.
- `sig_op`  out  3  ALU op: ADD 000, SUB 001, AND 010, OR 011, NOTA 100.
- `halted`  out  1  high while in HALT.
- `ill_err`  out  1  sticky illegal-instruction flag.
- `retire_cnt`  out  16  retired-instruction count (see Configuration).

## Operation
- Opcode is `inst[15:12]`. Rd/Rs is `inst[11:10]`, Rt is `inst[9:8]`.
- `0000` LW: R[rd] ← MEM[`inst[9:0]`]. Controls: rf_write=1, mem_read=1, memtoreg=0, pc_src=2.
- `0001` SW: MEM[`inst[9:0]`] ← R[rd]. Controls: alu_sel=1, mem_write=1, pc_src=2.
- `0010` J: pc_src=0.
- `0100` BZ: alu_sel=1, alu_src=1, op=SUB. pc_src=1 if `zero`, otherwise 2.
- `1000` ALU-R: R[rd] ← R[rd] op R[rt], where op = `inst[2:0]`. Controls: alu_sel=1, alu_src=0, memtoreg=1, rf_write=1, pc_src=2. An op value of 101–111 is illegal.
- `1100` LI: R[rd] ← `{8'h00,inst[7:0]}`. Controls: alu_sel=0, alu_src=1, op=ADD, memtoreg=1, rf_write=1, pc_src=2.
- `1110` WND: mode is `inst[11:10]`.
  - 00: window ← `inst[2:0]`.
  - 01: window+1, wrapping 7→0.
  - 10: window−1, wrapping 0→7.
  - 11: illegal.
  - No RF or MEM write; pc_src=2.
- `1111` HALT: no writes; pc_src=0. The assembler encodes the instruction's own address in `inst[9:0]`, so the PC parks on the HALT.
- Illegal (any other opcode, or the illegal sub-codes above): executes as a NOP (all enables 0, pc_src=2) and sets `ill_err`.
- Default control values for fields not listed: all enables 0, alu_sel=0, alu_src=0, memtoreg=1, op=ADD.

State machine:
- RUN: decode as above. A HALT instruction moves the FSM to HALT at the clock edge.
- HALT: forces rf_write, mem_write and mem_read to 0 and pc_src to 0; asserts `halted`. Only `rst` exits HALT.

## Timing
- Control outputs are combinational from `inst`, `zero`, the state and the window register, with zero-cycle latency.
- The window register updates at the edge that ends the WND cycle. The next instruction sees the new window; the WND instruction itself sees the old one.
- `ill_err` is set at the edge that ends the illegal cycle.
- While `rst`=1: all write/read enables are 0 and pc_src=2, regardless of `inst`.
- Values at the edge where `rst`=1: state=RUN, `sig_rf_wnd`=0, `halted`=0, `ill_err`=0, `retire_cnt`=0.
- `rst` asserted while halted or in mid-program returns to RUN on the next edge; pending WND or illegal effects in that cycle are discarded.

## Configuration
- `MIPS_CTRL_RETIRE_CNT_EN` defined: `retire_cnt` increments at each edge where `rst`=0 and state=RUN. This includes the HALT instruction once and illegal NOPs. The counter saturates at 16'hFFFF.
- Macro undefined: the counter is not synthesized and `retire_cnt` is tied to 16'h0000. The port list does not change.

## Structure
- `mips_sc_pkg` holds:
  - opcode constants;
  - ALU op constants (ADD…NOTA);
  - pc_src constants (JMP=0, BR=1, INC=2);
  - WND mode constants;
  - the RUN/HALT state typedef.
- One sub-module, `mips_sc_decoder`: purely combinational, mapping `inst`+`zero` to raw controls plus `is_halt`, `is_wnd` and `is_ill`.
- `mips_sc_ctrl` itself contains the FSM, the window register, the error flag, the counter, and the HALT/reset override gating.

## Test plan
- Reset: hold `rst` 2 cycles with `inst`=16'h0000 → enables 0, pc_src=2, wnd=0, halted=0, ill_err=0, retire_cnt=0.
- BZ: `inst`=16'h4412 with zero=1 → pc_src=1; with zero=0 → pc_src=2; op=001, alu_sel=1, alu_src=1, no writes.
- WND: apply 16'hE005, then 16'hE400 twice, then 16'hE800 → wnd 5, 6, 7, then 6. Also wnd 7 with 16'hE400 → 0, and wnd 0 with 16'hE800 → 7.
- ALU-R/LI/LW/SW: 16'h8403 → op=011, rf_write=1, memtoreg=1. 16'hC4AB → alu_sel=0, alu_src=1, op=000, rf_write=1. 16'h0123 → mem_read=1, memtoreg=0. 16'h1123 → mem_write=1, alu_sel=1.
- HALT: 16'hF010 in RUN → pc_src=0, no writes; `halted`=1 next cycle. Then apply 16'h8400 → rf_write stays 0. Pulse `rst` → RUN.
- Illegal/counter: 16'h3000 and 16'h8407 → NOP, ill_err=1 persisting after legal instructions. With the macro defined, 5 RUN instructions then 3 HALT cycles → retire_cnt=5.
